fir_interp_complex: RTL and testbench

//  Polyphase complex FIR interpolator; inverse direction of the complex decimating FIR.

---
 rtl/fir_interp_complex_if.sv | 27 ++
 rtl/fir_interp_complex.sv | 152 +++++++++++++++
 tb/tb_fir_interp_complex.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_interp_complex_if.sv
// FIFO-side bundle of the complex interpolator: I/Q input FIFOs in, real/imag output FIFOs out.
interface fir_interp_complex_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] i_in;
    logic                  i_empty;
    logic                  i_rd_en;
    logic [DATA_WIDTH-1:0] q_in;
    logic                  q_empty;
    logic                  q_rd_en;
    logic [DATA_WIDTH-1:0] real_out;
    logic                  real_wr_en;
    logic                  real_full;
    logic [DATA_WIDTH-1:0] imag_out;
    logic                  imag_wr_en;
    logic                  imag_full;

    modport master (
        output i_in, i_empty, q_in, q_empty, real_full, imag_full,
        input  i_rd_en, q_rd_en, real_out, real_wr_en, imag_out, imag_wr_en
    );

    modport slave (
        input  i_in, i_empty, q_in, q_empty, real_full, imag_full,
        output i_rd_en, q_rd_en, real_out, real_wr_en, imag_out, imag_wr_en
    );
endinterface

// File: rtl/fir_interp_complex.sv
// Polyphase complex FIR interpolator: one I/Q pop yields INTERP real/imag pushes,
// each phase computed with a single complex MAC over TAP_NUMBER/INTERP history taps.
module fir_interp_complex #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAP_NUMBER = 20,
    parameter int unsigned INTERP     = 10,
    parameter int unsigned FRAC_BITS  = 10,
    // Linear-interpolation prototype; each polyphase pair sums to 1.0 (1024).
    parameter logic [TAP_NUMBER-1:0][DATA_WIDTH-1:0] REAL_COEFF = {
        32'd0,    32'd102,  32'd205,  32'd307,  32'd410,
        32'd512,  32'd614,  32'd717,  32'd819,  32'd922,
        32'd1024, 32'd922,  32'd819,  32'd717,  32'd614,
        32'd512,  32'd410,  32'd307,  32'd205,  32'd102
    },
    parameter logic [TAP_NUMBER-1:0][DATA_WIDTH-1:0] IMAG_COEFF = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    fir_interp_complex_if.slave  bus
);

    localparam int unsigned TPP = TAP_NUMBER / INTERP;
    localparam int unsigned PW  = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam int unsigned TW  = (TPP > 1) ? $clog2(TPP) : 1;
    localparam int unsigned CW  = (TAP_NUMBER > 1) ? $clog2(TAP_NUMBER) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(INTERP - 1);
    localparam logic [TW-1:0] TAP_LAST   = TW'(TPP - 1);

    typedef enum logic [1:0] {StRead, StMac, StWrite} state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [TW-1:0]         tap_q, tap_d;
    logic [DATA_WIDTH-1:0] acc_r_q, acc_r_d;
    logic [DATA_WIDTH-1:0] acc_i_q, acc_i_d;
    logic [DATA_WIDTH-1:0] hist_r_q [TPP];
    logic [DATA_WIDTH-1:0] hist_i_q [TPP];

    logic                  in_empty, out_full;
    logic                  shift, rd_en, wr_en;
    logic [DATA_WIDTH-1:0] out_r, out_i;
    logic [CW-1:0]         coef_idx;
    logic [DATA_WIDTH-1:0] h_r, h_i, x_r, x_i;

    // Signed full-width product, floor-shifted back to Q(FRAC_BITS), low word kept.
    function automatic logic [DATA_WIDTH-1:0] mul(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
        logic signed [2*DATA_WIDTH-1:0] p;
        p = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
            $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
        return DATA_WIDTH'(p >>> FRAC_BITS);
    endfunction

    assign in_empty = bus.i_empty | bus.q_empty;
    assign out_full = bus.real_full | bus.imag_full;

    assign coef_idx = CW'(32'(phase_q) + 32'(tap_q) * INTERP);
    assign h_r      = REAL_COEFF[coef_idx];
    assign h_i      = IMAG_COEFF[coef_idx];
    assign x_r      = hist_r_q[tap_q];
    assign x_i      = hist_i_q[tap_q];

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tap_d   = tap_q;
        acc_r_d = acc_r_q;
        acc_i_d = acc_i_q;
        shift   = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        out_r   = '0;
        out_i   = '0;
        unique case (state_q)
            StRead: begin
                // Gated by reset so the pop strobe stays low while held in reset.
                if (!in_empty && reset) begin
                    rd_en   = 1'b1;
                    shift   = 1'b1;
                    phase_d = '0;
                    tap_d   = '0;
                    acc_r_d = '0;
                    acc_i_d = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_r_d = acc_r_q + mul(h_r, x_r) - mul(h_i, x_i);
                acc_i_d = acc_i_q + mul(h_r, x_i) + mul(h_i, x_r);
                if (tap_q == TAP_LAST) begin
                    tap_d   = '0;
                    state_d = StWrite;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            StWrite: begin
                if (!out_full) begin
                    wr_en   = 1'b1;
                    out_r   = acc_r_q;
                    out_i   = acc_i_q;
                    acc_r_d = '0;
                    acc_i_d = '0;
                    tap_d   = '0;
                    if (phase_q == PHASE_LAST) begin
                        state_d = StRead;
                    end else begin
                        phase_d = phase_q + 1'b1;
                        state_d = StMac;
                    end
                end
            end
            default: state_d = StRead;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StRead;
            phase_q <= '0;
            tap_q   <= '0;
            acc_r_q <= '0;
            acc_i_q <= '0;
            for (int k = 0; k < TPP; k++) begin
                hist_r_q[k] <= '0;
                hist_i_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tap_q   <= tap_d;
            acc_r_q <= acc_r_d;
            acc_i_q <= acc_i_d;
            if (shift) begin
                hist_r_q[0] <= bus.i_in;
                hist_i_q[0] <= bus.q_in;
                for (int k = 1; k < TPP; k++) begin
                    hist_r_q[k] <= hist_r_q[k-1];
                    hist_i_q[k] <= hist_i_q[k-1];
                end
            end
        end
    end

    assign bus.i_rd_en    = rd_en;
    assign bus.q_rd_en    = rd_en;
    assign bus.real_wr_en = wr_en;
    assign bus.imag_wr_en = wr_en;
    assign bus.real_out   = out_r;
    assign bus.imag_out   = out_i;

endmodule

// File: tb/tb_fir_interp_complex.sv
// Directed bench: four interpolator instances with different coefficient sets, FIFO models
// on both sides, hand-computed expected outputs per scenario.
module tb_fir_interp_complex;

    localparam int N = 4;
    localparam logic [19:0][31:0] C1024 = {20{32'd1024}};
    localparam logic [19:0][31:0] C512  = {20{32'd512}};

    function automatic logic [19:0][31:0] ramp();
        logic [19:0][31:0] r;
        for (int j = 0; j < 20; j++) r[j] = 32'((j + 1) << 10);
        return r;
    endfunction
    localparam logic [19:0][31:0] RAMP = ramp();

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int viol    = 0;

    logic [31:0] hd_i [N];
    logic [31:0] hd_q [N];
    logic        emp  [N];
    logic        blk_i[N];
    logic        blk_q[N];
    logic        rf   [N];
    logic        imf  [N];
    logic        rd_w [N];
    logic        rdq_w[N];
    logic        wr_w [N];
    logic        wri_w[N];
    logic [31:0] ro_w [N];
    logic [31:0] io_w [N];
    bit          pend_pop[N];

    logic [31:0] src_i [N][$];
    logic [31:0] src_q [N][$];
    logic [31:0] got_r [N][$];
    logic [31:0] got_i [N][$];
    int          pop_cyc[N][$];
    int          wr_cyc [N][$];

    // 0: all 1024 real; 1: ramp real; 2: all 1024 imag; 3: all 512 real
    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam logic [19:0][31:0] RC = (g == 0) ? C1024 : (g == 1) ? RAMP :
                                           (g == 2) ? 640'd0 : C512;
        localparam logic [19:0][31:0] IC = (g == 2) ? C1024 : 640'd0;

        fir_interp_complex_if #(.DATA_WIDTH(32)) bus ();

        fir_interp_complex #(
            .DATA_WIDTH(32),
            .TAP_NUMBER(20),
            .INTERP    (10),
            .FRAC_BITS (10),
            .REAL_COEFF(RC),
            .IMAG_COEFF(IC)
        ) dut (
            .clock(clock),
            .reset(reset),
            .bus  (bus)
        );

        assign bus.i_in      = hd_i[g];
        assign bus.q_in      = hd_q[g];
        assign bus.i_empty   = emp[g] | blk_i[g];
        assign bus.q_empty   = emp[g] | blk_q[g];
        assign bus.real_full = rf[g];
        assign bus.imag_full = imf[g];
        assign rd_w[g]       = bus.i_rd_en;
        assign rdq_w[g]      = bus.q_rd_en;
        assign wr_w[g]       = bus.real_wr_en;
        assign wri_w[g]      = bus.imag_wr_en;
        assign ro_w[g]       = bus.real_out;
        assign io_w[g]       = bus.imag_out;
    end

    // Input FIFO model: pops requested in the previous cycle are applied just after the edge.
    initial forever begin
        logic [31:0] tmp;
        @(posedge clock);
        cyc++;
        #1;
        for (int g = 0; g < N; g++) begin
            if (pend_pop[g]) begin
                if (src_i[g].size() > 0) begin
                    tmp = src_i[g].pop_front();
                    tmp = src_q[g].pop_front();
                end
                pend_pop[g] = 1'b0;
            end
            emp[g]  = (src_i[g].size() == 0);
            hd_i[g] = emp[g] ? 32'd0 : src_i[g][0];
            hd_q[g] = emp[g] ? 32'd0 : src_q[g][0];
        end
    end

    // Mid-cycle monitor: records pops, writes and handshake invariant violations.
    initial forever begin
        @(negedge clock);
        for (int g = 0; g < N; g++) begin
            if (rd_w[g] === 1'b1) begin
                pend_pop[g] = 1'b1;
                pop_cyc[g].push_back(cyc);
            end
            if (wr_w[g] === 1'b1) begin
                got_r[g].push_back(ro_w[g]);
                got_i[g].push_back(io_w[g]);
                wr_cyc[g].push_back(cyc);
            end
            if ((rd_w[g] === 1'b1 && wr_w[g] === 1'b1) || rd_w[g] !== rdq_w[g] ||
                wr_w[g] !== wri_w[g])
                viol++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic push(input int g, input logic [31:0] a, input logic [31:0] b);
        src_i[g].push_back(a);
        src_q[g].push_back(b);
    endtask

    task automatic clear_logs(input int g);
        got_r[g].delete();
        got_i[g].delete();
        pop_cyc[g].delete();
        wr_cyc[g].delete();
    endtask

    task automatic wait_writes(input int g, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clock);
            #2;
            if (got_r[g].size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        push(3, 32'd1024, 32'd0);
        step(3);
        for (int g = 0; g < N; g++) begin
            n_tests++;
            if (rd_w[g] !== 1'b0) begin
                n_fail++; $display("FAIL reset_rd_en[%0d]: got %b expected 0", g, rd_w[g]);
            end
            n_tests++;
            if (wr_w[g] !== 1'b0) begin
                n_fail++; $display("FAIL reset_wr_en[%0d]: got %b expected 0", g, wr_w[g]);
            end
            n_tests++;
            if (ro_w[g] !== 32'd0 || io_w[g] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_out[%0d]: got %h/%h expected 0/0", g, ro_w[g], io_w[g]);
            end
        end
        src_i[3].delete();
        src_q[3].delete();
        step(1);
        reset = 1'b1;
        step(2);
    endtask

    task automatic test_dc();
        bit ok;
        int per_pop;
        logic [31:0] exp_r;
        clear_logs(0);
        for (int k = 0; k < 3; k++) push(0, 32'd1024, 32'd0);
        wait_writes(0, 30, 150, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL dc_timeout: got %0d writes expected 30", got_r[0].size());
        end
        step(40);
        n_tests++;
        if (got_r[0].size() != 30 || pop_cyc[0].size() != 3) begin
            n_fail++;
            $display("FAIL dc_counts: got %0d writes %0d pops expected 30 writes 3 pops",
                     got_r[0].size(), pop_cyc[0].size());
        end
        for (int k = 0; k < got_r[0].size(); k++) begin
            exp_r = (k < 10) ? 32'd1024 : 32'd2048;
            n_tests++;
            if (got_r[0][k] !== exp_r || got_i[0][k] !== 32'd0) begin
                n_fail++;
                $display("FAIL dc_out[%0d]: got %h/%h expected %h/0", k, got_r[0][k],
                         got_i[0][k], exp_r);
            end
        end
        if (pop_cyc[0].size() >= 2 && wr_cyc[0].size() >= 1) begin
            n_tests++;
            if (wr_cyc[0][0] - pop_cyc[0][0] != 3) begin
                n_fail++;
                $display("FAIL dc_latency: got %0d expected 3", wr_cyc[0][0] - pop_cyc[0][0]);
            end
            n_tests++;
            if (pop_cyc[0][1] - pop_cyc[0][0] != 31) begin
                n_fail++;
                $display("FAIL dc_period: got %0d expected 31", pop_cyc[0][1] - pop_cyc[0][0]);
            end
            per_pop = 0;
            foreach (wr_cyc[0][k]) if (wr_cyc[0][k] < pop_cyc[0][1]) per_pop++;
            n_tests++;
            if (per_pop != 10) begin
                n_fail++; $display("FAIL dc_writes_per_pop: got %0d expected 10", per_pop);
            end
        end
    endtask

    task automatic test_impulse();
        bit ok;
        logic [31:0] exp_r;
        clear_logs(1);
        push(1, 32'd1024, 32'd0);
        push(1, 32'd0, 32'd0);
        push(1, 32'd0, 32'd0);
        wait_writes(1, 30, 150, ok);
        step(40);
        n_tests++;
        if (got_r[1].size() != 30) begin
            n_fail++; $display("FAIL imp_count: got %0d expected 30", got_r[1].size());
        end
        for (int k = 0; k < got_r[1].size(); k++) begin
            exp_r = (k < 20) ? 32'((k + 1) << 10) : 32'd0;
            n_tests++;
            if (got_r[1][k] !== exp_r || got_i[1][k] !== 32'd0) begin
                n_fail++;
                $display("FAIL imp_out[%0d]: got %h/%h expected %h/0", k, got_r[1][k],
                         got_i[1][k], exp_r);
            end
        end
    endtask

    task automatic test_imag();
        bit ok;
        clear_logs(2);
        push(2, 32'd1024, 32'd0);
        wait_writes(2, 10, 60, ok);
        step(5);
        n_tests++;
        if (got_r[2].size() != 10) begin
            n_fail++; $display("FAIL imag_a_count: got %0d expected 10", got_r[2].size());
        end
        for (int k = 0; k < got_r[2].size(); k++) begin
            n_tests++;
            if (got_r[2][k] !== 32'd0 || got_i[2][k] !== 32'd1024) begin
                n_fail++;
                $display("FAIL imag_a[%0d]: got %h/%h expected 0/400", k, got_r[2][k],
                         got_i[2][k]);
            end
        end
        pulse_reset();
        clear_logs(2);
        push(2, 32'd0, 32'd1024);
        wait_writes(2, 10, 60, ok);
        step(5);
        n_tests++;
        if (got_r[2].size() != 10) begin
            n_fail++; $display("FAIL imag_b_count: got %0d expected 10", got_r[2].size());
        end
        for (int k = 0; k < got_r[2].size(); k++) begin
            n_tests++;
            if (got_r[2][k] !== 32'hFFFF_FC00 || got_i[2][k] !== 32'd0) begin
                n_fail++;
                $display("FAIL imag_b[%0d]: got %h/%h expected fffffc00/0", k, got_r[2][k],
                         got_i[2][k]);
            end
        end
    endtask

    task automatic test_floor();
        bit ok;
        logic [31:0] exp_i;
        clear_logs(3);
        push(3, 32'hFFFF_FFFD, 32'd0);
        push(3, 32'd0, 32'hFFFF_FFFD);
        wait_writes(3, 20, 120, ok);
        step(5);
        n_tests++;
        if (got_r[3].size() != 20) begin
            n_fail++; $display("FAIL floor_count: got %0d expected 20", got_r[3].size());
        end
        for (int k = 0; k < got_r[3].size(); k++) begin
            exp_i = (k < 10) ? 32'd0 : 32'hFFFF_FFFE;
            n_tests++;
            if (got_r[3][k] !== 32'hFFFF_FFFE || got_i[3][k] !== exp_i) begin
                n_fail++;
                $display("FAIL floor_out[%0d]: got %h/%h expected fffffffe/%h", k,
                         got_r[3][k], got_i[3][k], exp_i);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        pulse_reset();
        clear_logs(0);
        rf[0] = 1'b1;
        push(0, 32'd1024, 32'd0);
        step(12);
        n_tests++;
        if (got_r[0].size() != 0 || pop_cyc[0].size() != 1) begin
            n_fail++;
            $display("FAIL bp_real_full: got %0d writes %0d pops expected 0 writes 1 pop",
                     got_r[0].size(), pop_cyc[0].size());
        end
        rf[0] = 1'b0;
        wait_writes(0, 1, 5, ok);
        imf[0] = 1'b1;
        step(10);
        n_tests++;
        if (got_r[0].size() != 1) begin
            n_fail++; $display("FAIL bp_imag_full: got %0d writes expected 1", got_r[0].size());
        end
        imf[0] = 1'b0;
        wait_writes(0, 10, 60, ok);
        step(3);
        n_tests++;
        if (got_r[0].size() != 10) begin
            n_fail++; $display("FAIL bp_count: got %0d expected 10", got_r[0].size());
        end
        for (int k = 0; k < got_r[0].size(); k++) begin
            n_tests++;
            if (got_r[0][k] !== 32'd1024 || got_i[0][k] !== 32'd0) begin
                n_fail++;
                $display("FAIL bp_out[%0d]: got %h/%h expected 400/0", k, got_r[0][k],
                         got_i[0][k]);
            end
        end
        blk_i[0] = 1'b1;
        push(0, 32'd1024, 32'd0);
        step(10);
        n_tests++;
        if (pop_cyc[0].size() != 1) begin
            n_fail++; $display("FAIL bp_i_empty: got %0d pops expected 1", pop_cyc[0].size());
        end
        blk_i[0] = 1'b0;
        wait_writes(0, 20, 60, ok);
        n_tests++;
        if (!ok || got_r[0][10] !== 32'd2048) begin
            n_fail++;
            $display("FAIL bp_resume: got %0d writes, out %h expected 20 writes, 800",
                     got_r[0].size(), ok ? got_r[0][10] : 32'd0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        step(3);
        clear_logs(0);
        push(0, 32'd1024, 32'd0);
        wait_writes(0, 4, 40, ok);
        reset = 1'b0;
        #1;
        n_tests++;
        if (rd_w[0] !== 1'b0 || wr_w[0] !== 1'b0 || ro_w[0] !== 32'd0 || io_w[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_out: got rd %b wr %b out %h/%h expected all 0", rd_w[0],
                     wr_w[0], ro_w[0], io_w[0]);
        end
        step(3);
        reset = 1'b1;
        step(5);
        n_tests++;
        if (got_r[0].size() != 4) begin
            n_fail++; $display("FAIL mid_reset_drop: got %0d writes expected 4", got_r[0].size());
        end
        push(0, 32'd1024, 32'd0);
        wait_writes(0, 5, 20, ok);
        n_tests++;
        if (!ok || got_r[0][4] !== 32'd1024) begin
            n_fail++;
            $display("FAIL mid_reset_first: got %h expected 400", ok ? got_r[0][4] : 32'd0);
        end
        wait_writes(0, 14, 60, ok);
        step(3);
    endtask

    task automatic test_back_to_back();
        n_tests++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL handshake_invariants: got %0d violations expected 0", viol);
        end
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            hd_i[g]     = '0;
            hd_q[g]     = '0;
            emp[g]      = 1'b1;
            blk_i[g]    = 1'b0;
            blk_q[g]    = 1'b0;
            rf[g]       = 1'b0;
            imf[g]      = 1'b0;
            pend_pop[g] = 1'b0;
        end
        test_reset();
        test_dc();
        test_impulse();
        test_imag();
        test_floor();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
